// File: rtl/mood_level_classifier.sv
// ---------------------------------------------------------------------------
// mood_level_classifier
//
// Purpose:
//    Turns the N-bit value of a saturating mood/stress counter into one of
//    three discrete levels (LOW / MID / HIGH). A hysteresis band sits around
//    each boundary. A candidate transition must also hold for DWELL
//    consecutive enabled cycles before it is taken. Together these stop
//    counter jitter from making the level chatter.
//
// Ports:
//    clk         in   1   clock, all state updates on the rising edge
//    rst_n       in   1   synchronous, active-low reset
//    value       in   N   counter value being classified
//    enable      in   1   low freezes the dwell counter and blocks transitions
//    level       out  2   2'b00 LOW, 2'b01 MID, 2'b10 HIGH (2'b11 never driven)
//    changed     out  1   one-cycle pulse in the cycle level takes a new value
//    dwell_busy  out  1   high while a transition is pending (dwell non-zero)
//
// Configuration:
//    MOOD_LEVEL_DIRECT_JUMP_EN - when defined, LOW can jump straight to HIGH
//    and HIGH straight to LOW if the value is beyond the far boundary.
//    Without it, every transition moves a single level step.
// ---------------------------------------------------------------------------
module mood_level_classifier #(
   parameter int N      = 8,
   parameter int T_LOW  = 64,
   parameter int T_HIGH = 192,
   parameter int HYST   = 8,
   parameter int DWELL  = 4,
   parameter int DW_W   = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] value,
   input  logic         enable,
   output logic [1:0]   level,
   output logic         changed,
   output logic         dwell_busy
);

   typedef enum logic [1:0] {
      LVL_LOW  = 2'b00,
      LVL_MID  = 2'b01,
      LVL_HIGH = 2'b10
   } level_t;

   // A dwell of 0 behaves exactly like a dwell of 1 (fire on first qualifying cycle)
   localparam int DWELL_EFF = (DWELL < 1) ? 1 : DWELL;

   // Band edges: up-moves use >=, down-moves use strict <
   localparam logic [N-1:0] LM_UP = N'(T_LOW + HYST);
   localparam logic [N-1:0] ML_DN = N'(T_LOW - HYST);
   localparam logic [N-1:0] MH_UP = N'(T_HIGH + HYST);
   localparam logic [N-1:0] HM_DN = N'(T_HIGH - HYST);

   localparam logic [DW_W:0] DW_ONE   = (DW_W+1)'(1);
   localparam logic [DW_W:0] DW_LIMIT = (DW_W+1)'(DWELL_EFF);

   // Reject parameter sets where the bands overlap or leave the value range,
   // or where the dwell counter cannot reach the dwell target
   generate
      if (!(HYST >= 0 && HYST <= T_LOW &&
            (T_LOW + HYST) < (T_HIGH - HYST) &&
            (T_HIGH + HYST) <= ((2 ** N) - 1))) begin : g_bad_bands
         $error("mood_level_classifier: illegal T_LOW/T_HIGH/HYST for N");
      end
      if ((2 ** DW_W) <= DWELL_EFF) begin : g_bad_dwell
         $error("mood_level_classifier: DW_W too narrow for DWELL");
      end
   endgenerate

   logic [N-1:0]    v_q;
   level_t          state_q;
   level_t          prev_target_q;
   logic [DW_W-1:0] dwell_q;

   level_t          cand_target;
   logic            cand_valid;
   logic [DW_W:0]   dwell_inc;
   logic            dwell_fire;

   assign level = state_q;

   // Work out which level, if any, the registered value is pulling us toward.
   // The thresholds depend on the current level, and that dependence is what
   // creates the hysteresis. In MID the down and up candidates can never
   // both be true, because the legal parameter ranges keep the bands apart.
   always_comb begin
      cand_valid  = 1'b0;
      cand_target = state_q;
      case (state_q)
         LVL_LOW: begin
`ifdef MOOD_LEVEL_DIRECT_JUMP_EN
            if (v_q >= MH_UP) begin
               cand_valid  = 1'b1;
               cand_target = LVL_HIGH;
            end else if (v_q >= LM_UP) begin
               cand_valid  = 1'b1;
               cand_target = LVL_MID;
            end
`else
            if (v_q >= LM_UP) begin
               cand_valid  = 1'b1;
               cand_target = LVL_MID;
            end
`endif
         end
         LVL_MID: begin
            if (v_q < ML_DN) begin
               cand_valid  = 1'b1;
               cand_target = LVL_LOW;
            end else if (v_q >= MH_UP) begin
               cand_valid  = 1'b1;
               cand_target = LVL_HIGH;
            end
         end
         LVL_HIGH: begin
`ifdef MOOD_LEVEL_DIRECT_JUMP_EN
            if (v_q < ML_DN) begin
               cand_valid  = 1'b1;
               cand_target = LVL_LOW;
            end else if (v_q < HM_DN) begin
               cand_valid  = 1'b1;
               cand_target = LVL_MID;
            end
`else
            if (v_q < HM_DN) begin
               cand_valid  = 1'b1;
               cand_target = LVL_MID;
            end
`endif
         end
         default: begin
            cand_valid  = 1'b0;
            cand_target = state_q;
         end
      endcase
   end

   // Work out the dwell count this edge would produce. A count that starts
   // from zero, or a candidate that has changed since the last enabled edge,
   // begins again at 1. The counter is one bit wider here so the increment
   // cannot wrap before it is compared with the dwell limit.
   always_comb begin
      dwell_inc = DW_ONE;
      if (dwell_q != '0 && cand_target == prev_target_q) begin
         dwell_inc = {1'b0, dwell_q} + DW_ONE;
      end
      dwell_fire = (dwell_inc >= DW_LIMIT);
   end

   // Main band FSM. The input is always registered, even when enable is low,
   // so the first qualifying evaluation happens one edge after a value is
   // sampled. Enable only gates the dwell counter and level changes. Reset
   // wins over everything, including a pending dwell.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v_q           <= '0;
         state_q       <= LVL_LOW;
         prev_target_q <= LVL_LOW;
         dwell_q       <= '0;
         changed       <= 1'b0;
         dwell_busy    <= 1'b0;
      end else begin
         v_q     <= value;
         changed <= 1'b0;
         if (enable) begin
            if (!cand_valid) begin
               dwell_q    <= '0;
               dwell_busy <= 1'b0;
            end else if (dwell_fire) begin
               state_q    <= cand_target;
               dwell_q    <= '0;
               dwell_busy <= 1'b0;
               changed    <= 1'b1;
            end else begin
               dwell_q    <= dwell_inc[DW_W-1:0];
               dwell_busy <= 1'b1;
            end
            if (cand_valid) begin
               prev_target_q <= cand_target;
            end
         end
      end
   end

endmodule

// File: tb/tb_mood_level_classifier.sv
// ---------------------------------------------------------------------------
// tb_mood_level_classifier
//
// Directed bench for mood_level_classifier with default parameters
// (N=8, T_LOW=64, T_HIGH=192, HYST=8, DWELL=4). Each step drives the inputs
// just after a rising edge. Outputs are checked 1 time unit after the next
// rising edge, against hand-computed level / changed / dwell_busy values.
// ---------------------------------------------------------------------------
module tb_mood_level_classifier;

   logic       clk;
   logic       rst_n;
   logic [7:0] value;
   logic       enable;
   logic [1:0] level;
   logic       changed;
   logic       dwell_busy;

   int total = 0;
   int bad   = 0;

   mood_level_classifier #(
      .N(8), .T_LOW(64), .T_HIGH(192), .HYST(8), .DWELL(4), .DW_W(4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .value      (value),
      .enable     (enable),
      .level      (level),
      .changed    (changed),
      .dwell_busy (dwell_busy)
   );

   // Free-running clock, period 10
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Drive one cycle of inputs, let one rising edge pass, then check all outputs
   task automatic applyStimulus(input string tag, input int v, input bit en,
                                input bit r, input int exp_level,
                                input int exp_changed, input int exp_busy);
      value  = 8'(v);
      enable = en;
      rst_n  = r;
      @(posedge clk);
      #1;
      checkOutput({tag, ".level"},   int'(level),      exp_level);
      checkOutput({tag, ".changed"}, int'(changed),    exp_changed);
      checkOutput({tag, ".busy"},    int'(dwell_busy), exp_busy);
   endtask

   // Go from MID (v_q above 56) back down to LOW with value=40
   task automatic dropToLow(input string tag);
      applyStimulus(tag, 40, 1, 1, 1, 0, 0);
      applyStimulus(tag, 40, 1, 1, 1, 0, 1);
      applyStimulus(tag, 40, 1, 1, 1, 0, 1);
      applyStimulus(tag, 40, 1, 1, 1, 0, 1);
      applyStimulus(tag, 40, 1, 1, 0, 1, 0);
   endtask

   initial begin
      value  = 8'd0;
      enable = 1'b1;
      rst_n  = 1'b0;

      // Test 1: reset with 200 held, then LOW -> MID -> HIGH one step at a time
      for (int i = 0; i < 3; i++) applyStimulus("t1_rst", 200, 1, 0, 0, 0, 0);
      applyStimulus("t1_s1",  200, 1, 1, 0, 0, 0);
      applyStimulus("t1_s2",  200, 1, 1, 0, 0, 1);
      applyStimulus("t1_s3",  200, 1, 1, 0, 0, 1);
      applyStimulus("t1_s4",  200, 1, 1, 0, 0, 1);
      applyStimulus("t1_mid", 200, 1, 1, 1, 1, 0);
      applyStimulus("t1_s6",  200, 1, 1, 1, 0, 1);
      applyStimulus("t1_s7",  200, 1, 1, 1, 0, 1);
      applyStimulus("t1_s8",  200, 1, 1, 1, 0, 1);
      applyStimulus("t1_hi",  200, 1, 1, 2, 1, 0);
      applyStimulus("t1_s10", 200, 1, 1, 2, 0, 0);

      // Test 2: HIGH -> MID with 150, then hold 56 on the strict edge, then 55 -> LOW
      applyStimulus("t2_d1",  150, 1, 1, 2, 0, 0);
      applyStimulus("t2_d2",  150, 1, 1, 2, 0, 1);
      applyStimulus("t2_d3",  150, 1, 1, 2, 0, 1);
      applyStimulus("t2_d4",  150, 1, 1, 2, 0, 1);
      applyStimulus("t2_mid", 150, 1, 1, 1, 1, 0);
      for (int i = 0; i < 20; i++) applyStimulus("t2_56", 56, 1, 1, 1, 0, 0);
      applyStimulus("t2_55a", 55, 1, 1, 1, 0, 0);
      applyStimulus("t2_55b", 55, 1, 1, 1, 0, 1);
      applyStimulus("t2_55c", 55, 1, 1, 1, 0, 1);
      applyStimulus("t2_55d", 55, 1, 1, 1, 0, 1);
      applyStimulus("t2_low", 55, 1, 1, 0, 1, 0);
      applyStimulus("t2_post", 55, 1, 1, 0, 0, 0);

      // Test 3: interrupted burst of 72 clears the dwell; second burst reaches MID
      applyStimulus("t3_a1", 72, 1, 1, 0, 0, 0);
      applyStimulus("t3_a2", 72, 1, 1, 0, 0, 1);
      applyStimulus("t3_a3", 72, 1, 1, 0, 0, 1);
      applyStimulus("t3_60", 60, 1, 1, 0, 0, 1);
      applyStimulus("t3_b1", 72, 1, 1, 0, 0, 0);
      applyStimulus("t3_b2", 72, 1, 1, 0, 0, 1);
      applyStimulus("t3_b3", 72, 1, 1, 0, 0, 1);
      applyStimulus("t3_b4", 72, 1, 1, 0, 0, 1);
      applyStimulus("t3_mid", 72, 1, 1, 1, 1, 0);

      // Test 4: dwell frozen by enable=0, resumes where it left off
      dropToLow("t4_drop");
      applyStimulus("t4_e1", 72, 1, 1, 0, 0, 0);
      applyStimulus("t4_e2", 72, 1, 1, 0, 0, 1);
      applyStimulus("t4_e3", 72, 1, 1, 0, 0, 1);
      for (int i = 0; i < 10; i++) applyStimulus("t4_frz", 72, 0, 1, 0, 0, 1);
      applyStimulus("t4_r1",  72, 1, 1, 0, 0, 1);
      applyStimulus("t4_mid", 72, 1, 1, 1, 1, 0);

      // Test 5: reset discards a pending dwell; a full dwell is needed afterwards
      dropToLow("t5_drop");
      applyStimulus("t5_q1", 100, 1, 1, 0, 0, 0);
      applyStimulus("t5_q2", 100, 1, 1, 0, 0, 1);
      applyStimulus("t5_q3", 100, 1, 1, 0, 0, 1);
      applyStimulus("t5_q4", 100, 1, 1, 0, 0, 1);
      applyStimulus("t5_rst", 100, 1, 0, 0, 0, 0);
      applyStimulus("t5_p1", 100, 1, 1, 0, 0, 0);
      applyStimulus("t5_p2", 100, 1, 1, 0, 0, 1);
      applyStimulus("t5_p3", 100, 1, 1, 0, 0, 1);
      applyStimulus("t5_p4", 100, 1, 1, 0, 0, 1);
      applyStimulus("t5_mid", 100, 1, 1, 1, 1, 0);

      // Test 6: large jump from LOW with 255
      applyStimulus("t6_rst", 255, 1, 0, 0, 0, 0);
      applyStimulus("t6_s1", 255, 1, 1, 0, 0, 0);
      applyStimulus("t6_s2", 255, 1, 1, 0, 0, 1);
      applyStimulus("t6_s3", 255, 1, 1, 0, 0, 1);
      applyStimulus("t6_s4", 255, 1, 1, 0, 0, 1);
`ifdef MOOD_LEVEL_DIRECT_JUMP_EN
      applyStimulus("t6_hi", 255, 1, 1, 2, 1, 0);
      for (int i = 0; i < 5; i++) applyStimulus("t6_hold", 255, 1, 1, 2, 0, 0);
`else
      applyStimulus("t6_mid", 255, 1, 1, 1, 1, 0);
      applyStimulus("t6_s6",  255, 1, 1, 1, 0, 1);
      applyStimulus("t6_s7",  255, 1, 1, 1, 0, 1);
      applyStimulus("t6_s8",  255, 1, 1, 1, 0, 1);
      applyStimulus("t6_hi",  255, 1, 1, 2, 1, 0);
      applyStimulus("t6_hold", 255, 1, 1, 2, 0, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
